// File: rtl/div_seq_pkg.sv
// div_seq_pkg: shared ALU op codes and decoder funct codes for the divide path,
// plus a helper that recognises the two divide operations.
package div_seq_pkg;

  localparam int ALU_OP_W = 8;

  // ALU control codes produced by the ALU decoder
  localparam logic [ALU_OP_W-1:0] EXE_DIV_OP  = 8'b0001_1010;
  localparam logic [ALU_OP_W-1:0] EXE_DIVU_OP = 8'b0001_1011;
  localparam logic [ALU_OP_W-1:0] EXE_AND_OP  = 8'b0010_0100;

  // R-type funct codes the decoder maps onto the divide ops
  localparam logic [5:0] EXE_DIV  = 6'b01_1010;
  localparam logic [5:0] EXE_DIVU = 6'b01_1011;

  function automatic logic is_div_op(input logic [ALU_OP_W-1:0] op);
    return (op == EXE_DIV_OP) || (op == EXE_DIVU_OP);
  endfunction

endpackage

// File: rtl/div_seq_if.sv
// div_seq_if: EX-stage handshake between the pipeline and the divide sequencer.
//   alucontrol, start_i, annul_i, srca, srcb : pipeline -> divider
//   stall_o, ready_o, result_o               : divider -> pipeline
// master = pipeline side, slave = divider side.
interface div_seq_if
  import div_seq_pkg::*;
#(
  parameter int WIDTH = 32
);
  logic [ALU_OP_W-1:0] alucontrol;
  logic                start_i;
  logic                annul_i;
  logic [WIDTH-1:0]    srca;
  logic [WIDTH-1:0]    srcb;
  logic                stall_o;
  logic                ready_o;
  logic [2*WIDTH-1:0]  result_o;

  modport master (
    output alucontrol, start_i, annul_i, srca, srcb,
    input  stall_o, ready_o, result_o
  );

  modport slave (
    input  alucontrol, start_i, annul_i, srca, srcb,
    output stall_o, ready_o, result_o
  );
endinterface

// File: rtl/div_step.sv
// div_step: one combinational restoring-division iteration.
//   rem      in  WIDTH+1  partial remainder
//   quo      in  WIDTH    quotient / remaining dividend bits
//   dvsr     in  WIDTH    divisor magnitude
//   rem_next out WIDTH+1  partial remainder after this step
//   quo_next out WIDTH    quotient after this step
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] dvsr,
  output logic [WIDTH:0]   rem_next,
  output logic [WIDTH-1:0] quo_next
);

  logic [WIDTH+1:0]        shifted;
  logic signed [WIDTH+1:0] trial;

  always_comb begin
    // One extra guard bit keeps the trial subtraction's sign unambiguous
    shifted = {rem, quo[WIDTH-1]};
    trial   = $signed(shifted) - $signed({2'b00, dvsr});
    if (!trial[WIDTH+1]) begin
      rem_next = trial[WIDTH:0];
      quo_next = {quo[WIDTH-2:0], 1'b1};
    end else begin
      rem_next = shifted[WIDTH:0];
      quo_next = {quo[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/div_seq.sv
// div_seq: multi-cycle signed/unsigned restoring divider for the EX stage.
//   clk  in   system clock
//   rst  in   asynchronous active-low reset
//   bus  slave handshake: alucontrol/start_i/annul_i/srca/srcb in,
//        stall_o (combinational), ready_o and result_o {rem, quo} (registered) out
module div_seq
  import div_seq_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input logic      clk,
  input logic      rst,
  div_seq_if.slave bus
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    DONE  = 2'd2,
    DZERO = 2'd3
  } state_t;

  state_t               state;
  state_t               state_nxt;
  logic [CNT_W-1:0]     cnt;
  logic [WIDTH:0]       rem_q;
  logic [WIDTH-1:0]     quo_q;
  logic [WIDTH-1:0]     dvsr_q;
  logic                 q_neg;
  logic                 r_neg;
  logic                 ready_q;
  logic [2*WIDTH-1:0]   result_q;

  logic                 accept;
  logic                 signed_op;
  logic                 last_step;
  logic [WIDTH:0]       rem_nxt;
  logic [WIDTH-1:0]     quo_nxt;

  function automatic logic [WIDTH-1:0] neg_if(input logic [WIDTH-1:0] v, input logic en);
    return en ? -v : v;
  endfunction

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem      (rem_q),
    .quo      (quo_q),
    .dvsr     (dvsr_q),
    .rem_next (rem_nxt),
    .quo_next (quo_nxt)
  );

  always_comb begin
    accept    = (state == IDLE) && bus.start_i && is_div_op(bus.alucontrol) && !bus.annul_i;
    signed_op = (bus.alucontrol == EXE_DIV_OP);
    last_step = (cnt == CNT_W'(WIDTH - 1));
    state_nxt = state;
    unique case (state)
      IDLE:    if (accept) state_nxt = (bus.srcb == '0) ? DZERO : BUSY;
      BUSY:    if (last_step) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      DZERO:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    // A flush wins over everything, including a same-cycle start
    if (bus.annul_i) state_nxt = IDLE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt      <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvsr_q   <= '0;
      q_neg    <= 1'b0;
      r_neg    <= 1'b0;
      ready_q  <= 1'b0;
      result_q <= '0;
    end else begin
      // Result is only driven during the single ready cycle
      ready_q  <= 1'b0;
      result_q <= '0;
      if (accept) begin
        // Magnitudes only in signed mode; 0x80.. maps to itself and still divides correctly
        cnt    <= '0;
        rem_q  <= '0;
        quo_q  <= neg_if(bus.srca, signed_op && bus.srca[WIDTH-1]);
        dvsr_q <= neg_if(bus.srcb, signed_op && bus.srcb[WIDTH-1]);
        q_neg  <= signed_op && (bus.srca[WIDTH-1] ^ bus.srcb[WIDTH-1]);
        r_neg  <= signed_op && bus.srca[WIDTH-1];
      end else if (state == BUSY) begin
        cnt   <= cnt + 1'b1;
        rem_q <= rem_nxt;
        quo_q <= quo_nxt;
      end
      // Registered outputs appear in the DONE/DZERO cycle itself
      if (state == BUSY && state_nxt == DONE) begin
        ready_q  <= 1'b1;
        result_q <= {neg_if(rem_nxt[WIDTH-1:0], r_neg), neg_if(quo_nxt, q_neg)};
      end else if (state_nxt == DZERO) begin
        ready_q  <= 1'b1;
      end
    end
  end

  assign bus.stall_o  = accept || (state == BUSY);
  assign bus.ready_o  = ready_q;
  assign bus.result_o = result_q;

endmodule

// File: tb/tb_div_seq.sv
// tb_div_seq: directed vector bench for div_seq. A table of divides with
// hand-computed {remainder, quotient}, latency and stall counts, plus short
// sequences for annul, reset and non-divide ops.
module tb_div_seq;
  import div_seq_pkg::*;

  logic clk;
  logic rst;

  div_seq_if #(.WIDTH(32)) bus ();

  div_seq #(.WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [7:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] res;
    int          lat;
    int          stalls;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Presents a divide, counts stall cycles and edges until ready_o, then
  // samples ready_o one cycle later. hold keeps start_i high with new
  // operands while busy (they must be ignored).
  task automatic run_div(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                         input bit hold, output int lat, output int stalls,
                         output logic [63:0] res, output bit got, output logic pulse_next);
    bus.alucontrol = op;
    bus.srca       = a;
    bus.srcb       = b;
    bus.start_i    = 1'b1;
    lat = 0; stalls = 0; res = '0; got = 1'b0; pulse_next = 1'b0;
    for (int i = 0; i < 100; i++) begin
      #1;
      if (bus.ready_o) begin
        got = 1'b1;
        res = bus.result_o;
        break;
      end
      if (bus.stall_o) stalls++;
      @(posedge clk); #1;
      lat++;
      if (hold) begin
        bus.srca = 32'd1;
        bus.srcb = 32'd1;
      end else begin
        bus.start_i = 1'b0;
      end
    end
    bus.start_i = 1'b0;
    @(posedge clk); #2;
    pulse_next = bus.ready_o;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          lat;
    int          stalls;
    logic [63:0] res;
    bit          got;
    logic        pulse;
    bit          seen;

    vecs[0]  = '{EXE_DIVU_OP, 32'd100,        32'd7,        64'h00000002_0000000E, 33, 33};
    vecs[1]  = '{EXE_DIV_OP,  32'hFFFFFF9C,   32'd7,        64'hFFFFFFFE_FFFFFFF2, 33, 33};
    vecs[2]  = '{EXE_DIV_OP,  32'd100,        32'hFFFFFFF9, 64'h00000002_FFFFFFF2, 33, 33};
    vecs[3]  = '{EXE_DIV_OP,  32'h80000000,   32'hFFFFFFFF, 64'h00000000_80000000, 33, 33};
    vecs[4]  = '{EXE_DIVU_OP, 32'hFFFFFFFF,   32'd1,        64'h00000000_FFFFFFFF, 33, 33};
    vecs[5]  = '{EXE_DIVU_OP, 32'h80000000,   32'hFFFFFFFF, 64'h80000000_00000000, 33, 33};
    vecs[6]  = '{EXE_DIV_OP,  32'hFFFFFFF9,   32'd2,        64'hFFFFFFFF_FFFFFFFD, 33, 33};
    vecs[7]  = '{EXE_DIV_OP,  32'hFFFFFFF8,   32'hFFFFFFFE, 64'h00000000_00000004, 33, 33};
    vecs[8]  = '{EXE_DIVU_OP, 32'd1000,       32'd33,       64'h0000000A_0000001E, 33, 33};
    vecs[9]  = '{EXE_DIVU_OP, 32'hFFFFFFFF,   32'hFFFFFFFE, 64'h00000001_00000001, 33, 33};
    vecs[10] = '{EXE_DIV_OP,  32'd1234,       32'd0,        64'h0,                 1,  1};
    vecs[11] = '{EXE_DIVU_OP, 32'hFFFFFFFF,   32'd0,        64'h0,                 1,  1};
    vecs[12] = '{EXE_DIVU_OP, 32'd5,          32'd10,       64'h00000005_00000000, 33, 33};

    rst = 1'b0;
    bus.alucontrol = '0;
    bus.start_i    = 1'b0;
    bus.annul_i    = 1'b0;
    bus.srca       = '0;
    bus.srcb       = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_stall",  {63'b0, bus.stall_o}, 64'd0);
    check("rst_ready",  {63'b0, bus.ready_o}, 64'd0);
    check("rst_result", bus.result_o,         64'd0);
    rst = 1'b1;
    @(posedge clk); #2;

    // Table of divides, issued back to back
    for (int v = 0; v < 13; v++) begin
      run_div(vecs[v].op, vecs[v].a, vecs[v].b, 1'b0, lat, stalls, res, got, pulse);
      check($sformatf("v%0d_ready", v),  {63'b0, got},  64'd1);
      check($sformatf("v%0d_result", v), res,           vecs[v].res);
      check($sformatf("v%0d_latency", v), lat,          vecs[v].lat);
      check($sformatf("v%0d_stalls", v), stalls,        vecs[v].stalls);
      check($sformatf("v%0d_pulse", v),  {63'b0, pulse}, 64'd0);
    end

    // start_i held during BUSY with changed operands is ignored
    run_div(EXE_DIVU_OP, 32'd1000, 32'd33, 1'b1, lat, stalls, res, got, pulse);
    check("hold_result",  res, 64'h0000000A_0000001E);
    check("hold_latency", lat, 64'd33);

    // Annul at iteration 10, then an immediate new divide
    bus.alucontrol = EXE_DIVU_OP;
    bus.srca = 32'd100; bus.srcb = 32'd7; bus.start_i = 1'b1;
    @(posedge clk); #1;
    bus.start_i = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("annul_busy_stall", {63'b0, bus.stall_o}, 64'd1);
    bus.annul_i = 1'b1;
    @(posedge clk); #1;
    bus.annul_i = 1'b0;
    #1;
    check("annul_idle_stall", {63'b0, bus.stall_o}, 64'd0);
    check("annul_no_ready",   {63'b0, bus.ready_o}, 64'd0);
    run_div(EXE_DIVU_OP, 32'd9, 32'd3, 1'b0, lat, stalls, res, got, pulse);
    check("after_annul_result",  res, 64'h00000000_00000003);
    check("after_annul_latency", lat, 64'd33);

    // Annul beats a same-cycle start
    bus.alucontrol = EXE_DIV_OP;
    bus.srca = 32'd100; bus.srcb = 32'd7; bus.start_i = 1'b1; bus.annul_i = 1'b1;
    #1;
    check("annul_prio_stall", {63'b0, bus.stall_o}, 64'd0);
    @(posedge clk); #1;
    bus.start_i = 1'b0; bus.annul_i = 1'b0;
    #1;
    check("annul_prio_idle", {63'b0, bus.stall_o}, 64'd0);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (bus.ready_o) seen = 1'b1;
    end
    check("annul_prio_no_ready", {63'b0, seen}, 64'd0);

    // Non-divide op is ignored
    bus.alucontrol = EXE_AND_OP;
    bus.srca = 32'd100; bus.srcb = 32'd7; bus.start_i = 1'b1;
    #1;
    check("and_no_stall", {63'b0, bus.stall_o}, 64'd0);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (bus.ready_o || bus.stall_o) seen = 1'b1;
    end
    check("and_no_ready", {63'b0, seen}, 64'd0);
    bus.start_i = 1'b0;
    @(posedge clk); #2;

    // Reset mid-BUSY clears outputs without waiting for a clock
    bus.alucontrol = EXE_DIVU_OP;
    bus.srca = 32'd100; bus.srcb = 32'd7; bus.start_i = 1'b1;
    @(posedge clk); #1;
    bus.start_i = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("midbusy_stall_pre", {63'b0, bus.stall_o}, 64'd1);
    rst = 1'b0;
    #1;
    check("midbusy_stall", {63'b0, bus.stall_o}, 64'd0);
    check("midbusy_ready", {63'b0, bus.ready_o}, 64'd0);
    check("midbusy_result", bus.result_o, 64'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #2;

    // Reset during the ready cycle clears a live result
    bus.alucontrol = EXE_DIV_OP;
    bus.srca = 32'hFFFFFF9C; bus.srcb = 32'd7; bus.start_i = 1'b1;
    @(posedge clk); #1;
    bus.start_i = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (bus.ready_o) begin
        got = 1'b1;
        break;
      end
    end
    check("rst_ready_seen", {63'b0, got}, 64'd1);
    check("rst_ready_pre_result", bus.result_o, 64'hFFFFFFFE_FFFFFFF2);
    rst = 1'b0;
    #1;
    check("rst_ready_ready",  {63'b0, bus.ready_o}, 64'd0);
    check("rst_ready_result", bus.result_o, 64'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/div_seq.md
# div_seq

Multi-cycle sequencer for the integer divide path of the EX stage. It accepts a decoded ALU control code and two 32-bit operands, and runs a 32-iteration restoring division, signed or unsigned. While busy it stalls the pipeline and finally returns a 64-bit {remainder, quotient} pair for the HI/LO registers. It sits beside the single-cycle ALU and is driven by the same `alucontrol` bus that the ALU decoder produces.

## Interface
Parameters:
- `WIDTH`, default 32: operand width. The iteration count equals `WIDTH`.

Ports:
- `clk`  in  1  system clock. All state changes on its rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `alucontrol`  in  8  decoded ALU op. Only `EXE_DIV_OP` (signed) and `EXE_DIVU_OP` (unsigned) start a division. All other codes are ignored.
- `start_i`  in  1  EX-stage instruction valid. Qualifies `alucontrol`.
- `annul_i`  in  1  flush from an exception or branch squash. Aborts any division in progress.
- `srca`  in  WIDTH  dividend.
- `srcb`  in  WIDTH  divisor.
- `stall_o`  out  1  holds the pipeline until the result is ready.
- `ready_o`  out  1  result valid for exactly one cycle.
- `result_o`  out  2*WIDTH  {remainder[63:32], quotient[31:0]}. Valid only while `ready_o` is high.

## Operation
- States: IDLE, BUSY, DONE, DZERO.
- A start is accepted when all of these hold: state is IDLE, `start_i` is high, `alucontrol` is a divide op, and `annul_i` is low.
- On an accepted start:
  - Latch the sign mode.
  - Latch `|srca|` and `|srcb|`. Magnitudes are taken only in signed mode.
  - Latch the quotient sign (`srca[31]^srcb[31]`) and the remainder sign (`srca[31]`).
- Transition out of IDLE on an accepted start:
  - If `srcb == 0`, go to DZERO.
  - Otherwise clear the iteration counter and go to BUSY.
- BUSY, each cycle performs one restoring step on a (WIDTH+1)-bit partial remainder:
  - Shift {rem, quo} left by 1.
  - Compute trial = rem − divisor.
  - If trial is non-negative, set rem = trial and quo[0] = 1.
  - Increment the counter. After the WIDTH-th step, go to DONE.
- DONE:
  - `ready_o` = 1.
  - Negate the quotient if its latched sign is set, and the remainder if its latched sign is set (two's complement).
  - Return to IDLE.
- DZERO:
  - `ready_o` = 1 with `result_o` = all zeros. No trap is raised.
  - Return to IDLE.
- Signed corner case: 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000 and remainder 0. This falls out of the magnitude arithmetic naturally; no special case is needed.
- `annul_i` high in any state forces IDLE on the next edge, and `ready_o` is not asserted for the aborted op. Annul takes priority over a same-cycle start.
- `start_i` while in BUSY or DONE is ignored. The pipeline is stalled, so the same instruction is re-presented after `ready_o`. The EX/MEM latch must capture the result during the `ready_o` cycle.

## Timing
- Reset values: state IDLE, `stall_o` = 0, `ready_o` = 0, `result_o` = 0, counter = 0, operand registers = 0.
- `stall_o` is combinational. It is high:
  - in IDLE when an accepted start is present,
  - throughout BUSY.
- `stall_o` is low in DONE, DZERO and IDLE-without-start, so the pipeline advances in the `ready_o` cycle.
- `ready_o` and `result_o` are registered outputs of DONE/DZERO.
- Latency, start-accept edge to `ready_o`:
  - nonzero divisor: WIDTH+1 cycles (32 BUSY cycles, then DONE; 33 for the default width).
  - zero divisor: 1 cycle.
- Back-to-back divides: the earliest next accept is the cycle after `ready_o`, i.e. the first IDLE cycle.
- Reset mid-BUSY: immediate return to IDLE with all outputs cleared.

## Structure
- The shared defines header holds `EXE_DIV_OP` and `EXE_DIVU_OP` (8-bit ALU op codes) and the `EXE_DIV`/`EXE_DIVU` funct codes that the ALU decoder maps onto them. No local copies of these codes.
- State encodings are local `localparam`s. They are not shared.
- One natural sub-module, `div_step`: purely combinational single restoring iteration. Inputs are partial remainder, quotient and divisor; outputs are the next partial remainder and next quotient. The counter, FSM, sign fix-up and handshake stay in `div_seq`.

## Test plan
- DIVU: 100 / 7 → `stall_o` high for 33 cycles, then `ready_o` with result {0x00000002, 0x0000000E}.
- DIV: −100 / 7 → result {0xFFFFFFFE, 0xFFFFFFF2}. DIV 100 / −7 → result {0x00000002, 0xFFFFFFF2}.
- DIV: 0x80000000 / 0xFFFFFFFF → result {0x00000000, 0x80000000}. DIVU 0xFFFFFFFF / 1 → quotient 0xFFFFFFFF, remainder 0.
- Divide by zero (either mode) → `ready_o` exactly 1 cycle after the accept, result all zeros, `stall_o` high for only the accept cycle.
- `annul_i` asserted at iteration 10 → IDLE the next cycle, no `ready_o`. Then a new DIVU 9 / 3 is accepted the following cycle and gives {0, 3}.
- `rst` low mid-BUSY → all outputs 0 immediately. `start_i` with a non-divide `alucontrol` (e.g. the AND op) → no stall, no `ready_o`.
